// File: rtl/second_top.sv
// Four-tap FIR multiply-accumulate with a shifting 16-bit sample window.
// One tap is processed per enabled cycle. tapnum==3 publishes the finished
// sum on result_o and raises done for exactly one cycle.
module second_top (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en_i,
  input  logic        signal_en,
  input  logic [23:0] signal,
  input  logic [15:0] tapcoeff,
  input  logic [7:0]  tapnum,
  output logic [32:0] result_o,
  output logic        done
);

  logic signed [15:0] win_q [4];
  logic signed [15:0] win_d [4];
  logic signed [32:0] acc_q, acc_d;
  logic signed [32:0] result_q, result_d;
  logic               done_q, done_d;

  logic signed [31:0] coef_ext;
  logic signed [31:0] samp_ext;
  logic signed [31:0] prod;
  logic signed [32:0] prod_ext;

  // Only the top 16 bits of each audio sample enter the window.
  logic unused_signal_lsbs;
  assign unused_signal_lsbs = ^signal[7:0];

  // Product uses the window as registered before this edge's shift.
  always_comb begin
    coef_ext = $signed({{16{tapcoeff[15]}}, tapcoeff});
    samp_ext = $signed({{16{win_q[tapnum[1:0]][15]}}, win_q[tapnum[1:0]]});
    prod     = coef_ext * samp_ext;
    prod_ext = $signed({prod[31], prod});
  end

  // Window shift, independent of the MAC enable.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      win_d[i] = win_q[i];
    end
    if (signal_en) begin
      win_d[3] = win_q[2];
      win_d[2] = win_q[1];
      win_d[1] = win_q[0];
      win_d[0] = $signed(signal[23:8]);
    end
  end

  // Accumulator, result and done next-state; sums wrap modulo 2^33.
  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (clk_en_i) begin
      case (tapnum)
        8'd0: acc_d = prod_ext;
        8'd1,
        8'd2: acc_d = acc_q + prod_ext;
        8'd3: begin
          result_d = acc_q + prod_ext;
          acc_d    = '0;
          done_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over both enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        win_q[i] <= '0;
      end
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        win_q[i] <= win_d[i];
      end
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign done     = done_q;

endmodule

// File: tb/tb_second_top.sv
// Directed bench for second_top: a vector table with one clock per record,
// followed by a hand-written done-pulse-count sequence.
module tb_second_top;

  logic        clk;
  logic        reset;
  logic        clk_en_i;
  logic        signal_en;
  logic [23:0] signal;
  logic [15:0] tapcoeff;
  logic [7:0]  tapnum;
  logic [32:0] result_o;
  logic        done;

  int n_checks = 0;
  int n_fails  = 0;

  second_top dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en_i (clk_en_i),
    .signal_en(signal_en),
    .signal   (signal),
    .tapcoeff (tapcoeff),
    .tapnum   (tapnum),
    .result_o (result_o),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sen;
    logic        cen;
    logic [23:0] sig;
    logic [15:0] coef;
    logic [7:0]  tn;
    logic [32:0] exp_res;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic sen, input logic cen, input logic [23:0] sig,
                     input logic [15:0] coef, input logic [7:0] tn,
                     input logic [32:0] exp_res, input logic exp_done);
    vec_t v;
    v.rst = rst; v.sen = sen; v.cen = cen; v.sig = sig;
    v.coef = coef; v.tn = tn; v.exp_res = exp_res; v.exp_done = exp_done;
    vecs.push_back(v);
  endtask

  task automatic check_res(input string name, input logic [32:0] exp);
    n_checks++;
    if (result_o !== exp) begin
      n_fails++;
      $display("FAIL %s: result_o got %h expected %h", name, result_o, exp);
    end
  endtask

  task automatic check_done(input string name, input logic exp);
    n_checks++;
    if (done !== exp) begin
      n_fails++;
      $display("FAIL %s: done got %b expected %b", name, done, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic sen, input logic cen, input logic [23:0] sig,
                       input logic [15:0] coef, input logic [7:0] tn);
    reset = rst; signal_en = sen; clk_en_i = cen; signal = sig; tapcoeff = coef; tapnum = tn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    reset = 1'b0; signal_en = 1'b0; clk_en_i = 1'b0;
    signal = '0; tapcoeff = '0; tapnum = '0;

    // rst sen cen signal coef tapnum  expected result / done
    add(1, 0, 0, 24'h0, 16'h0, 8'd0, 33'h0, 0);             // 0 reset state
    add(0, 1, 0, 24'h000400, 16'h0, 8'd0, 33'h0, 0);        // 1..4 window = [1,2,3,4]
    add(0, 1, 0, 24'h000300, 16'h0, 8'd0, 33'h0, 0);
    add(0, 1, 0, 24'h000200, 16'h0, 8'd0, 33'h0, 0);
    add(0, 1, 0, 24'h000100, 16'h0, 8'd0, 33'h0, 0);
    add(0, 0, 1, 24'h0, 16'd4, 8'd0, 33'h0, 0);             // 5..8 4+2+6+4 = 16
    add(0, 0, 1, 24'h0, 16'd1, 8'd1, 33'h0, 0);
    add(0, 0, 1, 24'h0, 16'd2, 8'd2, 33'h0, 0);
    add(0, 0, 1, 24'h0, 16'd1, 8'd3, 33'd16, 1);
    add(0, 0, 1, 24'h0, 16'd0, 8'd4, 33'd16, 0);            // 9 pulse ends
    add(0, 0, 1, 24'h0, 16'd3, 8'd0, 33'd16, 0);            // 10..13 all taps 3 -> 30
    add(0, 0, 1, 24'h0, 16'd3, 8'd1, 33'd16, 0);
    add(0, 0, 1, 24'h0, 16'd3, 8'd2, 33'd16, 0);
    add(0, 0, 1, 24'h0, 16'd3, 8'd3, 33'd30, 1);
    add(0, 0, 1, 24'h0, 16'd3, 8'd4, 33'd30, 0);            // 14..15 hold with tapnum 4
    add(0, 0, 1, 24'h0, 16'd3, 8'd4, 33'd30, 0);
    add(0, 0, 1, 24'h0, 16'd4, 8'd0, 33'd30, 0);            // 16..21 paused sequence
    add(0, 0, 1, 24'h0, 16'd1, 8'd1, 33'd30, 0);
    add(0, 0, 0, 24'h0, 16'd1, 8'd3, 33'd30, 0);            // disabled, must not finish
    add(0, 0, 0, 24'h0, 16'd7, 8'd0, 33'd30, 0);            // disabled, must not restart
    add(0, 0, 1, 24'h0, 16'd2, 8'd2, 33'd30, 0);
    add(0, 0, 1, 24'h0, 16'd1, 8'd3, 33'd16, 1);
    add(0, 0, 0, 24'h0, 16'd0, 8'd0, 33'd16, 0);            // 22
    add(0, 0, 1, 24'h0, 16'd1, 8'd3, 33'd4, 1);             // 23..24 back-to-back finishes
    add(0, 0, 1, 24'h0, 16'd2, 8'd3, 33'd8, 1);
    add(0, 0, 0, 24'h0, 16'd0, 8'd3, 33'd8, 0);
    add(0, 0, 1, 24'h0, 16'd1, 8'd0, 33'd8, 0);             // 26 acc = 1
    add(0, 0, 1, 24'h0, 16'd9, 8'd5, 33'd8, 0);             // 27 out-of-range tap holds acc
    add(0, 0, 1, 24'h0, 16'd1, 8'd3, 33'd5, 1);             // 28 1 + 4
    add(0, 0, 1, 24'h0, 16'd4, 8'd0, 33'd5, 0);             // 29..30 partial sum 6
    add(0, 0, 1, 24'h0, 16'd1, 8'd1, 33'd5, 0);
    add(1, 1, 1, 24'h7F0000, 16'd1, 8'd3, 33'h0, 0);        // 31 reset beats both enables
    add(0, 0, 1, 24'h0, 16'd1, 8'd3, 33'h0, 1);             // 32 aborted sum is gone
    add(0, 0, 1, 24'h0, 16'd4, 8'd0, 33'h0, 0);             // 33..36 zero window
    add(0, 0, 1, 24'h0, 16'd1, 8'd1, 33'h0, 0);
    add(0, 0, 1, 24'h0, 16'd2, 8'd2, 33'h0, 0);
    add(0, 0, 1, 24'h0, 16'd1, 8'd3, 33'h0, 1);
    add(0, 1, 0, 24'hFFFF00, 16'h0, 8'd0, 33'h0, 0);        // 37 win[0] = -1
    add(0, 0, 1, 24'h0, 16'd2, 8'd0, 33'h0, 0);             // 38..41 -> -2
    add(0, 0, 1, 24'h0, 16'd0, 8'd1, 33'h0, 0);
    add(0, 0, 1, 24'h0, 16'd0, 8'd2, 33'h0, 0);
    add(0, 0, 1, 24'h0, 16'd0, 8'd3, 33'h1_FFFF_FFFE, 1);
    add(0, 1, 1, 24'h000500, 16'd1, 8'd0, 33'h1_FFFF_FFFE, 0); // 42 pre-shift win[0] = -1
    add(0, 0, 1, 24'h0, 16'd3, 8'd1, 33'h1_FFFF_FFFE, 0);   // 43 win[1] = -1 -> acc -4
    add(0, 0, 1, 24'h0, 16'd1, 8'd3, 33'h1_FFFF_FFFC, 1);   // 44 win[3] = 0
    add(0, 1, 0, 24'h800000, 16'h0, 8'd0, 33'h1_FFFF_FFFC, 0); // 45..48 window all -32768
    add(0, 1, 0, 24'h800000, 16'h0, 8'd0, 33'h1_FFFF_FFFC, 0);
    add(0, 1, 0, 24'h800000, 16'h0, 8'd0, 33'h1_FFFF_FFFC, 0);
    add(0, 1, 0, 24'h800000, 16'h0, 8'd0, 33'h1_FFFF_FFFC, 0);
    add(0, 0, 1, 24'h0, 16'h8000, 8'd0, 33'h1_FFFF_FFFC, 0); // 49..52 4 * 2^30
    add(0, 0, 1, 24'h0, 16'h8000, 8'd1, 33'h1_FFFF_FFFC, 0);
    add(0, 0, 1, 24'h0, 16'h8000, 8'd2, 33'h1_FFFF_FFFC, 0);
    add(0, 0, 1, 24'h0, 16'h8000, 8'd3, 33'h1_0000_0000, 1);
    add(0, 0, 0, 24'h0, 16'h8000, 8'd3, 33'h1_0000_0000, 0); // 53

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].sen, vecs[i].cen, vecs[i].sig, vecs[i].coef, vecs[i].tn);
      check_res($sformatf("vec%0d_result", i), vecs[i].exp_res);
      check_done($sformatf("vec%0d_done", i), vecs[i].exp_done);
    end

    // Window still all -32768; taps of 1 give -131072. Exactly one done pulse
    // must appear across the sequence and the idle cycles after it.
    pulses = 0;
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, 1'b0, 1'b1, 24'h0, 16'd1, 8'(t));
      if (done === 1'b1) pulses++;
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b0, 24'h0, 16'd1, 8'd3);
      if (done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fails++;
      $display("FAIL pulse_count: got %0d pulses expected 1", pulses);
    end
    check_res("neg_sum_hold", 33'h1_FFFE_0000);
    check_done("neg_sum_idle", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
